mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have a parameter MULT_CYC, default 5, giving the busy duration in cycles for mult and multu.
REQ-002 The block SHALL have a parameter DIV_CYC, default 10, giving the busy duration in cycles for div and divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse from the E stage launching the operation selected by op.
REQ-006 The block SHALL have port op, input, 2 bits: 00 mult, 01 multu, 10 div, 11 divu; sampled only when start is high.
REQ-007 The block SHALL have port hi_we, input, 1 bit: mthi write enable.
REQ-008 The block SHALL have port lo_we, input, 1 bit: mtlo write enable.
REQ-009 The block SHALL have port A, input, 32 bits: rs operand, also the mthi/mtlo data.
REQ-010 The block SHALL have port B, input, 32 bits: rt operand.
REQ-011 The block SHALL have port busy, output, 1 bit: operation in progress; drives the hazard unit's MD stall.
REQ-012 The block SHALL have port HI, output, 32 bits: HI register, the mfhi source.
REQ-013 The block SHALL have port LO, output, 32 bits: LO register, the mflo source.

Function
REQ-014 The block SHALL implement two states: IDLE (busy=0) and RUN (busy=1).
REQ-015 In IDLE with start=1 it SHALL latch A, B and op, load the cycle counter with MULT_CYC or DIV_CYC, and enter RUN at the next edge.
REQ-016 Busy SHALL be high for exactly N consecutive cycles, where N is the loaded count, starting the cycle after start.
REQ-017 HI/LO SHALL keep their old values throughout RUN and SHALL update on the same edge at which busy falls.
REQ-018 On that edge the block SHALL return to IDLE; a start in the first IDLE cycle SHALL be accepted.
REQ-019 mult and multu SHALL produce {HI,LO} equal to the signed or unsigned 64-bit product of A and B, respectively.
REQ-020 div and divu SHALL produce LO = quotient and HI = remainder; signed quotient truncates toward zero and the signed remainder takes the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-022 Division by zero SHALL still run DIV_CYC busy cycles and SHALL leave HI/LO unchanged.
REQ-023 A start asserted while busy=1 SHALL be ignored and SHALL not restart or extend the operation.
REQ-024 hi_we or lo_we in IDLE with start=0 SHALL write A into HI or LO, respectively, at the next edge.
REQ-025 When hi_we and lo_we are both high, both registers SHALL be written.
REQ-026 hi_we and lo_we SHALL be ignored while busy=1 or start=1; start takes priority.
REQ-027 busy, HI and LO SHALL be driven directly from registers with no combinational path from inputs.
REQ-028 The counter width SHALL hold max(MULT_CYC, DIV_CYC); both parameters are at least 1.

Reset
REQ-029 When reset=1 at a clock edge, the block SHALL force the state to IDLE, busy=0, HI=0, LO=0 and counter=0.
REQ-030 Reset SHALL override start, hi_we and lo_we in the same cycle.
REQ-031 Reset asserted mid-operation SHALL discard the pending result; HI/LO read 0 after that edge.

Verification
REQ-032 mult A=0xFFFFFFFD (-3), B=5 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-033 multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div A=0xFFFFFFF9 (-7), B=2 -> busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; HI/LO unchanged during cycles 1-10.
REQ-035 mthi A=0x1234 -> HI=0x1234; then divu B=0 -> 10 busy cycles, HI stays 0x1234.
REQ-036 During an active div: start (mult) plus hi_we -> both ignored, busy still falls at cycle 10 with the div result.
REQ-037 Start div, assert reset in busy cycle 3 -> next edge busy=0, HI=0, LO=0; no later update occurs.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl: multi-cycle multiply/divide unit controller with HI/LO registers.
//
// A one-cycle start pulse launches mult/multu/div/divu on the latched A/B.
// busy then stays high for MULT_CYC or DIV_CYC cycles. On the edge where busy
// falls, HI/LO take the result. mthi/mtlo writes (hi_we/lo_we) are accepted
// only in IDLE with no start.
//
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  synchronous active-high reset
//   start  in   1  launch pulse from E stage
//   op     in   2  00 mult, 01 multu, 10 div, 11 divu
//   hi_we  in   1  mthi write enable (data from A)
//   lo_we  in   1  mtlo write enable (data from A)
//   A      in  32  rs operand / mthi-mtlo data
//   B      in  32  rt operand
//   busy   out  1  operation in progress (registered)
//   HI     out 32  HI register
//   LO     out 32  LO register
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  // Products: sign- or zero-extend to 64 bits, low 64 bits of the product.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;

  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
  assign w_prod   = (r_op == OP_MULT) ? w_prod_s : w_prod_u;

  // Division via magnitudes so 0x80000000 / -1 has a defined result:
  // |0x80000000| = 0x80000000 unsigned, quotient sign positive -> 0x80000000.
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;

  assign w_signed_div = (r_op == OP_DIV);
  assign w_a_neg      = w_signed_div & r_a[31];
  assign w_b_neg      = w_signed_div & r_b[31];
  assign w_a_mag      = w_a_neg ? 32'(~r_a + 32'd1) : r_a;
  assign w_b_mag      = w_b_neg ? 32'(~r_b + 32'd1) : r_b;
  assign w_div_zero   = (r_b == 32'd0);
  // Keep the divider's divisor non-zero; the result is discarded in that case.
  assign w_b_safe     = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? 32'(~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem        = w_a_neg ? 32'(~w_r_mag + 32'd1) : w_r_mag;

  // Control FSM with registered busy/HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= A;
            r_b     <= B;
            r_cnt   <= op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            if (hi_we) r_hi <= A;
            if (lo_we) r_lo <= A;
          end
        end
        S_RUN: begin
          // Last busy cycle: drop busy and commit the result on the same edge.
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (r_op == OP_DIV || r_op == OP_DIVU) begin
              if (!w_div_zero) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
              end
            end else begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl: table-driven check of mdu_ctrl results and busy timing, plus
// directed sequences for mthi/mtlo, ignored starts, and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;
  localparam int          MAX_WAIT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .hi_we(hi_we), .lo_we(lo_we), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        keep;   // divide by zero: HI/LO must stay unchanged
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation in the current cycle and follow it to completion.
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input logic keep);
    logic [31:0] old_hi, old_lo;
    int n;
    old_hi = HI;
    old_lo = LO;
    start = 1'b1; op = t_op; A = t_a; B = t_b;
    tick();
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    n = 0;
    while (busy && n < MAX_WAIT) begin
      check("hold_during_run", {HI, LO}, {old_hi, old_lo});
      n++;
      tick();
    end
    check("busy_cycles", 64'(n), t_op[1] ? 64'(DIV_CYC) : 64'(MULT_CYC));
    if (keep) check("result_divzero", {HI, LO}, {old_hi, old_lo});
    else      check("result", {HI, LO}, {e_hi, e_lo});
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[5]  = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{2'b10, 32'd123,       32'd0,          32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{2'b10, 32'h8000_0000, 32'd7,          32'hFFFF_FFFE, 32'hEDB6_DB6E, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00; hi_we = 1'b0; lo_we = 1'b0; A = '0; B = '0;
    tick();
    tick();
    check("reset_state", {31'd0, busy, HI, LO}, 64'd0);
    reset = 1'b0;

    // mthi then divu by zero: HI keeps the mthi value.
    hi_we = 1'b1; A = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    check("mthi", 64'(HI), 64'h1234);
    run_op(2'b11, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1);
    check("divu0_hi_kept", 64'(HI), 64'h1234);

    // Back-to-back table: each start lands in the first IDLE cycle.
    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].keep);

    // hi_we/lo_we alongside start and throughout the run are ignored.
    hi_we = 1'b1; lo_we = 1'b1;
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    hi_we = 1'b0; lo_we = 1'b0;

    // Start(mult)+hi_we during an active div are ignored.
    begin
      logic [31:0] old_hi, old_lo;
      int n;
      old_hi = HI; old_lo = LO;
      start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < MAX_WAIT) begin
        check("div_hold_vs_start", {HI, LO}, {old_hi, old_lo});
        if (n == 2) begin
          start = 1'b1; op = 2'b00; hi_we = 1'b1; A = 32'h5555_5555; B = 32'd3;
        end else begin
          start = 1'b0; hi_we = 1'b0;
        end
        n++;
        tick();
      end
      start = 1'b0; hi_we = 1'b0;
      check("div_ignore_start_cycles", 64'(n), 64'(DIV_CYC));
      check("div_ignore_start_result", {HI, LO}, {32'd2, 32'd14});
      tick();
      check("no_restart", 64'(busy), 64'd0);
    end

    // Both write enables together write both registers.
    hi_we = 1'b1; lo_we = 1'b1; A = 32'h0000_AAAA;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo_both", {HI, LO}, {32'hAAAA, 32'hAAAA});

    // Reset in busy cycle 3 discards the pending div.
    start = 1'b1; op = 2'b10; A = 32'hFFFF_FFF9; B = 32'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_op_reset", {31'd0, busy, HI, LO}, 64'd0);
    for (int k = 0; k < 15; k++) begin
      tick();
      check("no_late_update", {31'd0, busy, HI, LO}, 64'd0);
    end

    // Reset overrides start and write enables in the same cycle.
    reset = 1'b1; start = 1'b1; op = 2'b00; hi_we = 1'b1; lo_we = 1'b1; A = 32'hFFFF_FFFF; B = 32'd9;
    tick();
    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("reset_priority", {31'd0, busy, HI, LO}, 64'd0);
    tick();
    check("reset_priority_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
